// File: rtl/status_xfer_scheduler_if.sv
// rtl/status_xfer_scheduler_if.sv - source request and handshaker transmit signals for status_xfer_scheduler
interface status_xfer_scheduler_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 2
);
    logic [NUM_SRC-1:0]            Src_Req;
    logic [NUM_SRC*DATA_WIDTH-1:0] Src_Data;
    logic [NUM_SRC-1:0]            Src_Ack;
    logic [DATA_WIDTH-1:0]         Tx_Data;
    logic [IDX_WIDTH-1:0]          Tx_Index;
    logic                          Tx_Start;
    logic                          Tx_Busy;
    logic [15:0]                   Xfer_Count;

    modport master (
        input  Src_Req, Src_Data, Tx_Busy,
        output Src_Ack, Tx_Data, Tx_Index, Tx_Start, Xfer_Count
    );

    modport slave (
        output Src_Req, Src_Data, Tx_Busy,
        input  Src_Ack, Tx_Data, Tx_Index, Tx_Start, Xfer_Count
    );
endinterface

// File: rtl/status_xfer_scheduler.sv
// rtl/status_xfer_scheduler.sv - round-robin share of one IO->Sys handshaker transmit channel
module status_xfer_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    status_xfer_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, GUARD, WAIT} state_t;

    localparam logic [IDX_WIDTH:0]   NSRC_W = (IDX_WIDTH+1)'(NUM_SRC);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SRC - 1);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic [IDX_WIDTH-1:0]   tx_index_q, tx_index_d;
    logic                   tx_start_q, tx_start_d;
    logic [NUM_SRC-1:0]     src_ack_q, src_ack_d;
    logic [15:0]            xfer_count_q, xfer_count_d;

    logic                   win_found;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic [IDX_WIDTH:0]     cand;

    // First requester at or after the pointer, wrapping past NUM_SRC-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, ptr_q} + (IDX_WIDTH+1)'(i);
            if (cand >= NSRC_W) begin
                cand = cand - NSRC_W;
            end
            if (!win_found && bus.Src_Req[cand[IDX_WIDTH-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        tx_data_d    = tx_data_q;
        tx_index_d   = tx_index_q;
        tx_start_d   = 1'b0;
        src_ack_d    = '0;
        xfer_count_d = xfer_count_q;
        case (state_q)
            IDLE: begin
                if (win_found && !bus.Tx_Busy) begin
                    tx_data_d          = bus.Src_Data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    tx_index_d         = win_idx;
                    tx_start_d         = 1'b1;
                    src_ack_d[win_idx] = 1'b1;
                    ptr_d              = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    state_d            = GUARD;
                end
            end
            // The handshaker may not have raised Busy yet, so it is not trusted here.
            GUARD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.Tx_Busy) begin
                    xfer_count_d = xfer_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            tx_data_q    <= '0;
            tx_index_q   <= '0;
            tx_start_q   <= 1'b0;
            src_ack_q    <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tx_data_q    <= tx_data_d;
            tx_index_q   <= tx_index_d;
            tx_start_q   <= tx_start_d;
            src_ack_q    <= src_ack_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.Tx_Data    = tx_data_q;
    assign bus.Tx_Index   = tx_index_q;
    assign bus.Tx_Start   = tx_start_q;
    assign bus.Src_Ack    = src_ack_q;
    assign bus.Xfer_Count = xfer_count_q;
endmodule

// File: tb/tb_status_xfer_scheduler.sv
// tb/tb_status_xfer_scheduler.sv - directed self-checking bench for status_xfer_scheduler
module tb_status_xfer_scheduler;
    localparam int NUM_SRC    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int IDX_WIDTH  = 2;

    logic Clock;
    logic Reset;
    int   n_tests;
    int   n_fail;
    int   cyc;
    logic [DATA_WIDTH-1:0] words [NUM_SRC];

    status_xfer_scheduler_if #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

    status_xfer_scheduler #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic wait_start(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.Tx_Start) seen = 1'b1;
        end
        check("start_seen", 64'(seen), 64'd1);
    endtask

    // Grant, then a short Busy pulse, returning with the scheduler back in IDLE.
    task automatic do_xfer(input logic [3:0] req, input int exp_idx, input string tag);
        logic seen;
        bus.Src_Req = req;
        wait_start(seen);
        if (seen) begin
            check({tag, "_idx"},  64'(bus.Tx_Index), 64'(exp_idx));
            check({tag, "_ack"},  64'(bus.Src_Ack),  64'(4'b0001 << exp_idx));
            check({tag, "_data"}, 64'(bus.Tx_Data),  64'(words[exp_idx]));
        end
        bus.Src_Req = '0;
        bus.Tx_Busy = 1'b1;
        tick();
        tick();
        bus.Tx_Busy = 1'b0;
        tick();
    endtask

    initial begin
        logic seen;
        logic any_start;
        int   last_cyc;
        int   idx;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        last_cyc = 0;
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h1111_AAAA;
        words[2] = 32'h2222_BBBB;
        words[3] = 32'h3333_CCCC;
        for (int i = 0; i < NUM_SRC; i++) bus.Src_Data[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
        bus.Src_Req = '0;
        bus.Tx_Busy = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        check("rst_start", 64'(bus.Tx_Start),   64'd0);
        check("rst_ack",   64'(bus.Src_Ack),    64'd0);
        check("rst_data",  64'(bus.Tx_Data),    64'd0);
        check("rst_index", 64'(bus.Tx_Index),   64'd0);
        check("rst_count", 64'(bus.Xfer_Count), 64'd0);
        Reset = 1'b0;

        // Single request with a 5-cycle Busy
        bus.Src_Req = 4'b0001;
        tick();
        check("single_start", 64'(bus.Tx_Start), 64'd1);
        check("single_ack",   64'(bus.Src_Ack),  64'h1);
        check("single_data",  64'(bus.Tx_Data),  64'hDEAD_BEEF);
        check("single_index", 64'(bus.Tx_Index), 64'd0);
        bus.Src_Req = '0;
        bus.Tx_Busy = 1'b1;
        tick();
        check("guard_start", 64'(bus.Tx_Start), 64'd0);
        check("guard_ack",   64'(bus.Src_Ack),  64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("wait_count", 64'(bus.Xfer_Count), 64'd0);
        check("wait_hold",  64'(bus.Tx_Data),    64'hDEAD_BEEF);
        bus.Tx_Busy = 1'b0;
        tick();
        check("single_count", 64'(bus.Xfer_Count), 64'd1);
        check("single_idle",  64'(bus.Tx_Start),   64'd0);

        // Round-robin from a fresh pointer with all sources requesting
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.Src_Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(seen);
            if (seen) begin
                idx = int'(bus.Tx_Index);
                check("rr_idx", 64'(bus.Tx_Index), 64'(k % 4));
                check("rr_ack", 64'(bus.Src_Ack),  64'(4'b0001 << (k % 4)));
                if (k > 0) check("rr_spacing_ge3", 64'(cyc - last_cyc >= 3), 64'd1);
                last_cyc = cyc;
                bus.Src_Req[idx] = 1'b0;
            end
            bus.Tx_Busy = 1'b1;
            tick();
            bus.Src_Req = (k == 4) ? 4'b0000 : 4'b1111;
            tick();
            tick();
            tick();
            bus.Tx_Busy = 1'b0;
        end
        tick();
        check("rr_count", 64'(bus.Xfer_Count), 64'd5);

        // Pointer fairness: after serving 2, 0101 wraps to 0, then 2
        do_xfer(4'b0100, 2, "ptr_a");
        do_xfer(4'b0101, 0, "ptr_wrap");
        do_xfer(4'b0101, 2, "ptr_next");

        // Busy blocks grants in IDLE
        bus.Tx_Busy = 1'b1;
        bus.Src_Req = 4'b0010;
        any_start   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_start |= bus.Tx_Start;
        end
        check("busy_block", 64'(any_start), 64'd0);
        bus.Tx_Busy = 1'b0;
        tick();
        check("busy_release_start", 64'(bus.Tx_Start), 64'd1);
        check("busy_release_index", 64'(bus.Tx_Index), 64'd1);
        bus.Src_Req = '0;
        tick();
        tick();

        // Withdrawal before grant
        bus.Tx_Busy = 1'b1;
        bus.Src_Req = 4'b1000;
        tick();
        bus.Src_Req = '0;
        tick();
        bus.Tx_Busy = 1'b0;
        any_start   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_start |= bus.Tx_Start;
        end
        check("withdraw_no_grant", 64'(any_start), 64'd0);

        // Reset while in WAIT
        bus.Src_Req = 4'b0001;
        wait_start(seen);
        bus.Src_Req = '0;
        bus.Tx_Busy = 1'b1;
        tick();
        Reset = 1'b1;
        tick();
        check("mid_rst_start", 64'(bus.Tx_Start),   64'd0);
        check("mid_rst_ack",   64'(bus.Src_Ack),    64'd0);
        check("mid_rst_count", 64'(bus.Xfer_Count), 64'd0);
        check("mid_rst_index", 64'(bus.Tx_Index),   64'd0);
        Reset = 1'b0;
        bus.Tx_Busy = 1'b0;
        do_xfer(4'b1111, 0, "post_rst_ptr0");

        // Counter wrap: preload near the top, then two real transfers
        force dut.xfer_count_q = 16'hFFFE;
        #1;
        release dut.xfer_count_q;
        do_xfer(4'b0010, 1, "wrap_a");
        check("wrap_ffff", 64'(bus.Xfer_Count), 64'hFFFF);
        do_xfer(4'b0100, 2, "wrap_b");
        check("wrap_zero", 64'(bus.Xfer_Count), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
